// File: rtl/pipelined_adder.sv
// pipelined_adder: parametrised, pipelined, registered adder/subtractor.
//   Operands split into STAGES chunks of CW = WIDTH/STAGES bits. Stage k adds
//   chunk k plus the carry registered by stage k-1. Valid/ready on both sides
//   with a global stall; one result per cycle in steady state.
// Ports:
//   clk, reset     - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready, a, b, c_in, sub - operand bundle handshake and payload
//   out_valid/out_ready, sum, c_out, ovf - result bundle handshake and payload
//   sub=0: a+b+c_in ; sub=1: a-b-c_in (c_out=1 means no borrow)
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned CW1  = CW + 1;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage registers: valid, chunk carry, deskewed result, skewed operands
    logic             vld_q [STAGES];
    logic             cy_q  [STAGES];
    logic [WIDTH-1:0] res_q [STAGES];
    logic [WIDTH-1:0] opa_q [STAGES];
    logic [WIDTH-1:0] opb_q [STAGES];
    logic             ovf_q;

    // Per-stage inputs (what each stage sees this cycle)
    logic             si_vld [STAGES];
    logic             si_cy  [STAGES];
    logic [WIDTH-1:0] si_res [STAGES];
    logic [WIDTH-1:0] si_a   [STAGES];
    logic [WIDTH-1:0] si_b   [STAGES];

    // Per-stage combinational results
    logic [CW:0]      ch     [STAGES];
    logic [WIDTH-1:0] nres   [STAGES];
    logic             ovf_d;

    logic             stall;

    // Global stall: everything holds while a result waits at the output
    assign stall     = vld_q[LAST] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_q[LAST];
    assign sum       = res_q[LAST];
    assign c_out     = cy_q[LAST];
    assign ovf       = ovf_q;

    // Stage input selection: stage 0 from the port (subtract mapped to add), others from the previous slot
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            si_vld[k] = 1'b0;
            si_cy[k]  = 1'b0;
            si_res[k] = '0;
            si_a[k]   = '0;
            si_b[k]   = '0;
        end
        si_vld[0] = in_valid;
        si_cy[0]  = sub ^ c_in;
        si_res[0] = '0;
        si_a[0]   = a;
        si_b[0]   = sub ? ~b : b;
        for (int unsigned k = 1; k < STAGES; k++) begin
            si_vld[k] = vld_q[k-1];
            si_cy[k]  = cy_q[k-1];
            si_res[k] = res_q[k-1];
            si_a[k]   = opa_q[k-1];
            si_b[k]   = opb_q[k-1];
        end
    end

    // Chunk adders; each stage merges its chunk sum into the deskew word
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            ch[k]   = CW1'(si_a[k][k*CW +: CW]) + CW1'(si_b[k][k*CW +: CW]) + CW1'(si_cy[k]);
            nres[k] = si_res[k] | (WIDTH'(ch[k][CW-1:0]) << (k*CW));
        end
        // Carry into the MSB equals a^b^sum at the MSB, so ovf needs no extra adder split
        ovf_d = si_a[LAST][WIDTH-1] ^ si_b[LAST][WIDTH-1] ^ nres[LAST][WIDTH-1] ^ ch[LAST][CW];
    end

    // Pipeline registers; the last slot only captures data for valid bundles so outputs hold across bubbles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                res_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vld_q[k] <= si_vld[k];
                opa_q[k] <= si_a[k];
                opb_q[k] <= si_b[k];
                if (k != LAST || si_vld[k]) begin
                    cy_q[k]  <= ch[k][CW];
                    res_q[k] <= nres[k];
                end
            end
            if (si_vld[LAST]) begin
                ovf_q <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table, streaming,
// backpressure, reset mid-flight, and latency for STAGES = 1, 4, 16.
module tb_pipelined_adder;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, c_in, sub, out_ready;
    logic [W-1:0] a, b;

    logic         in_ready4, out_valid4, c_out4, ovf4;
    logic [W-1:0] sum4;
    logic         in_ready1, out_valid1, c_out1, ovf1;
    logic [W-1:0] sum1;
    logic         in_ready16, out_valid16, c_out16, ovf16;
    logic [W-1:0] sum16;

    pipelined_adder #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid4),
        .out_ready(out_ready), .sum(sum4), .c_out(c_out4), .ovf(ovf4));

    pipelined_adder #(.WIDTH(W), .STAGES(1)) dut_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid1),
        .out_ready(out_ready), .sum(sum1), .c_out(c_out1), .ovf(ovf1));

    pipelined_adder #(.WIDTH(W), .STAGES(16)) dut_s16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid16),
        .out_ready(out_ready), .sum(sum16), .c_out(c_out16), .ovf(ovf16));

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         ci;
        logic         sb;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int emits    = 0;
    int accepts  = 0;
    int last_emit_cyc = 0;

    logic [W+1:0] exp_q[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum   = '0;
    logic [1:0]   prev_fl    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Golden model: {ovf, c_out, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] be;
        logic [W:0]   t;
        logic         ov;
        be = ms ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, ms ^ mc};
        ov = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
        return {ov, t};
    endfunction

    // One clock: drive at negedge, sample 1 ns later, run the scoreboard
    task automatic cycle(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic isb, input logic iord);
        logic [W+1:0] e;
        @(negedge clk);
        in_valid = v; a = ia; b = ib; c_in = ic; sub = isb; out_ready = iord;
        #1;
        cyc++;
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid4), 32'd1);
            chk("hold_sum", 32'(sum4), 32'(prev_sum));
            chk("hold_flags", 32'({c_out4, ovf4}), 32'(prev_fl));
        end
        if (out_valid4 && !out_ready) chk("stall_in_ready", 32'(in_ready4), 32'd0);
        if (out_valid4 && out_ready) begin
            emits++;
            last_emit_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0h required=none", sum4);
            end else begin
                e = exp_q.pop_front();
                chk("sb_result", 32'({ovf4, c_out4, sum4}), 32'(e));
            end
        end
        if (in_valid && in_ready4) begin
            exp_q.push_back(model(a, b, c_in, sub));
            accepts++;
        end
        prev_stall = out_valid4 && !out_ready;
        prev_sum   = sum4;
        prev_fl    = {c_out4, ovf4};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_q.delete();
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t vt[8];

    initial begin
        int lat, first, e0, a0, l1, l4, l16;
        logic found;
        logic [W-1:0] s1c, s16c;
        logic c1c, c16c;

        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        vt[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[7] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid4), 32'd0);
        chk("rst_sum", 32'(sum4), 32'd0);
        chk("rst_flags", 32'({c_out4, ovf4}), 32'd0);
        chk("rst_in_ready", 32'(in_ready4), 32'd1);
        chk("rst_valid_s1", 32'(out_valid1), 32'd0);
        chk("rst_valid_s16", 32'(out_valid16), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors: latency and exact result per bundle
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vt[i].va, vt[i].vb, vt[i].ci, vt[i].sb, 1'b1);
            lat = 0;
            found = 1'b0;
            for (int j = 1; j <= 8 && !found; j++) begin
                cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
                if (out_valid4) begin
                    found = 1'b1;
                    lat = j;
                    chk($sformatf("vec%0d_sum", i), 32'(sum4), 32'(vt[i].s));
                    chk($sformatf("vec%0d_c_out", i), 32'(c_out4), 32'(vt[i].co));
                    chk($sformatf("vec%0d_ovf", i), 32'(ovf4), 32'(vt[i].ov));
                end
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
        end
        idle(2);
        chk("idle_hold_sum", 32'(sum4), 32'(vt[7].s));

        // Streaming: 20 back-to-back bundles, one result per cycle, no gaps
        e0 = emits;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            if (emits != e0 && first < 0) first = last_emit_cyc;
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (emits != e0 && first < 0) first = last_emit_cyc;
        end
        chk("stream_count", 32'(emits - e0), 32'd20);
        chk("stream_span", 32'(last_emit_cyc - first), 32'd19);

        // Backpressure: 3 in flight, out_ready low for 5 cycles
        e0 = emits;
        a0 = accepts;
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            if (out_valid4) lat++;
        end
        chk("bp_stalled_cycles", 32'(lat), 32'd4);
        idle(10);
        chk("bp_count", 32'(emits - e0), 32'(accepts - a0));
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Random in_valid / out_ready toggling
        e0 = emits;
        a0 = accepts;
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom));
        idle(10);
        chk("rand_count", 32'(emits - e0), 32'(accepts - a0));
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-flight: two bundles, first just at the output when reset hits
        cycle(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 16'h2222, 16'h1111, 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("pre_reset_valid", 32'(out_valid4), 32'd1);
        chk("pre_reset_sum", 32'(sum4), 32'h2345);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid4), 32'd0);
        chk("mid_rst_sum", 32'(sum4), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready4), 32'd1);
        exp_q.delete();
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        e0 = emits;
        idle(8);
        chk("no_stale_result", 32'(emits - e0), 32'd0);

        // Wrap latency for STAGES = 1, 4, 16
        do_reset();
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        l1 = 0; l4 = 0; l16 = 0;
        s1c = '1; s16c = '1; c1c = 1'b0; c16c = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (out_valid1 && l1 == 0) begin l1 = j; s1c = sum1; c1c = c_out1; end
            if (out_valid4 && l4 == 0) l4 = j;
            if (out_valid16 && l16 == 0) begin l16 = j; s16c = sum16; c16c = c_out16; end
        end
        chk("lat_s1", 32'(l1), 32'd1);
        chk("lat_s4", 32'(l4), 32'd4);
        chk("lat_s16", 32'(l16), 32'd16);
        chk("wrap_s1_sum", 32'(s1c), 32'd0);
        chk("wrap_s1_c_out", 32'(c1c), 32'd1);
        chk("wrap_s16_sum", 32'(s16c), 32'd0);
        chk("wrap_s16_c_out", 32'(c16c), 32'd1);
        chk("wrap_s16_ovf", 32'(ovf16), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined, registered adder/subtractor. It is the multi-bit successor of the team's 1-bit registered full adder.
- Operands are split into STAGES equal chunks. Each pipeline stage computes one chunk and forwards its carry to the next stage through a register.
- Valid/ready handshakes on both sides; one result per cycle in steady state.
- Sits between operand-producing datapath logic and result consumers where a single-cycle WIDTH-bit carry chain would not meet timing.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be divisible by STAGES.
- STAGES, 4, number of pipeline stages. Must be 1 or more. Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (low) clears all state immediately; deassertion is synchronous to clk externally.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept the bundle this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in when adding; borrow-in when subtracting.
- sub  input  1  0 = A+B+c_in; 1 = A-B-c_in.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of MSB. When subtracting, 1 = no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Reset (reset=0, async): all stage valid bits, data, carry and skew registers clear to 0. Outputs out_valid=0, sum=0, c_out=0, ovf=0. in_ready=1 during and after reset.
- Operation mapping: b_eff = sub ? ~b : b; carry into LSB = sub ? ~c_in : c_in. Result = a + b_eff + carry_in, so sub computes A-B-c_in.
- Transfer in: occurs on a rising edge with in_valid & in_ready. a, b_eff, carry_in and sub are captured that edge.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff (bits k*CW .. k*CW+CW-1) plus the carry registered by stage k-1. Stage 0 uses the captured carry_in.
  - Registers the chunk sum and carry-out.
  - Upper chunks not yet consumed travel in skew registers; lower chunk results travel in deskew registers.
  - All fields of one bundle stay aligned in the same stage slot.
- Latency: a bundle accepted at edge T presents out_valid=1 with its result after edge T+STAGES-1. With STAGES=1 the result appears after edge T, so the latency is 1 cycle.
- Status flags:
  - c_out = carry out of the last chunk.
  - ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Stall (global): stall = out_valid & ~out_ready.
  - While stall=1, every stage register holds its value and in_ready=0.
  - in_ready = ~stall is combinational from out_ready.
- Bubbles: each stage has its own valid bit, and a stage loads even if its valid bit is 0. Bubbles propagate without collapsing. Throughput is 1 per cycle when in_valid=1 and out_ready=1 continuously.
- Output hold: while out_valid=1 and out_ready=0, sum, c_out and ovf must stay stable.
- Simultaneous accept and emit: allowed in the same cycle and required for full throughput.
- Reset mid-operation: all in-flight bundles are discarded. No result is emitted for them after reset deasserts.
- No X propagation: when out_valid=0, sum, c_out and ovf hold their last value (0 after reset).

Test Plan:
- Wrap: WIDTH=16, STAGES=4, a=0xFFFF, b=0x0001, c_in=0, sub=0, out_ready=1. Required: 4 cycles later out_valid=1, sum=0x0000, c_out=1, ovf=0; the carry must cross all chunks.
- Signed overflow: a=0x7FFF, b=0x0001, add. Required: sum=0x8000, c_out=0, ovf=1. Then a=0x8000, b=0x0001, sub=1, c_in=0. Required: sum=0x7FFF, c_out=1, ovf=1.
- Borrow: a=0x0005, b=0x0007, sub=1, c_in=1. Required: sum=0xFFFD, c_out=0, ovf=0.
- Streaming: 20 random back-to-back bundles, out_ready=1. Required: 20 results in order, one per cycle, each matching the golden model, with no gaps after the first result.
- Backpressure: with 3 bundles in flight, drop out_ready for 5 cycles. Required: in_ready=0 and the held output stays stable. On release, results arrive in order with none lost or duplicated. Also repeat the streaming scenario with random in_valid and out_ready toggling.
- Reset mid-flight: pull reset low 2 cycles after 2 bundles are accepted. Required: immediate out_valid=0, sum=0, in_ready=1, and no stale result after deassertion. Repeat the wrap scenario with STAGES=1 and STAGES=16, WIDTH=16. Required: latency is 1 and 16 cycles respectively.
